bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter and bus-cycle sequencer for the IOM memory/IO block.
- Accepts read/write requests from two masters and grants the shared bus to one of them at a time.
- Generates the T1/T2/T3/T4 strobe sequence (ALE, CS, RD, WR, Address, Data) that IOM expects.
- Returns read data and a completion pulse to the granted master.

---
 rtl/bus_arbiter.sv | 129 ++++++++++++
 tb/tb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter that runs the IOM T1..T4 bus cycle for the winner.
// Outputs are registered and update together with the state.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | bus free; arbitrate and latch the winner's request
//  S_T1   | ALE high, CS low, Address valid, grant asserted
//  S_T2   | CS low, RD or WR low, write data driven
//  S_T3   | strobe held; read data captured at the end of this cycle
//  S_T4   | strobes released, done pulse, write data still driven
module bus_arbiter #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] Address,
   output logic              ALE,
   output logic              CS,
   output logic              RD,
   output logic              WR,
   inout  wire  [DATA_W-1:0] Data
);

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_T1   = 5'b00010,
      S_T2   = 5'b00100,
      S_T3   = 5'b01000,
      S_T4   = 5'b10000
   } state_t;

   state_t            state;
   logic              ptr;
   logic              sel;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic              data_oe;
   logic              win;

   // With a single request the requester wins outright; on contention the pointer decides.
   assign win  = (req0 && req1) ? ptr : req1;
   assign Data = data_oe ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ptr     <= 1'b0;
         sel     <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         data_oe <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         rdata   <= '0;
         busy    <= 1'b0;
         Address <= '0;
         ALE     <= 1'b0;
         CS      <= 1'b1;
         RD      <= 1'b1;
         WR      <= 1'b1;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  sel     <= win;
                  ptr     <= ~win;
                  we_q    <= win ? we1 : we0;
                  Address <= win ? addr1 : addr0;
                  wdata_q <= win ? wdata1 : wdata0;
                  gnt0    <= ~win;
                  gnt1    <= win;
                  busy    <= 1'b1;
                  ALE     <= 1'b1;
                  CS      <= 1'b0;
                  state   <= S_T1;
               end
            end
            S_T1: begin
               ALE     <= 1'b0;
               RD      <= we_q;
               WR      <= ~we_q;
               data_oe <= we_q;
               state   <= S_T2;
            end
            S_T2: begin
               state <= S_T3;
            end
            S_T3: begin
               if (!we_q) rdata <= Data;
               CS    <= 1'b1;
               RD    <= 1'b1;
               WR    <= 1'b1;
               done0 <= ~sel;
               done1 <= sel;
               state <= S_T4;
            end
            S_T4: begin
               // Address is deliberately left holding the last transaction's value.
               data_oe <= 1'b0;
               gnt0    <= 1'b0;
               gnt1    <= 1'b0;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: IOM memory model on the bus, a transaction-level reference model
// predicting every cycle, and a done/rdata scoreboard checked by a separate monitor.
module tb_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [19:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [7:0]  rdata;
   logic [19:0] Address;
   logic        ALE, CS, RD, WR;
   wire  [7:0]  data_bus;

   bus_arbiter #(.ADDR_W(20), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .busy(busy), .Address(Address),
      .ALE(ALE), .CS(CS), .RD(RD), .WR(WR), .Data(data_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_val(input logic [19:0] a);
      case (a)
         20'h00010: return 8'hA5;
         20'h00020: return 8'h11;
         20'h00001: return 8'h3E;
         20'h00002: return 8'hC1;
         default:   return a[7:0] ^ a[19:12];
      endcase
   endfunction

   // ---------------- IOM memory on the bus ----------------
   logic [7:0] iom [logic [19:0]];
   logic [7:0] iom_val;
   logic       wr_seen;

   function automatic logic [7:0] iom_rd(input logic [19:0] a);
      return iom.exists(a) ? iom[a] : init_val(a);
   endfunction

   assign data_bus = (!RD && !CS) ? iom_val : 8'hzz;

   // The write lands on the edge that ends the second WR-low cycle (end of T3).
   always @(posedge clk) begin
      if (rst) wr_seen = 1'b0;
      else begin
         if (!WR && wr_seen) iom[Address] = data_bus;
         wr_seen = !WR;
      end
      iom_val = iom_rd(Address);
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic       who;
      logic       we;
      logic [7:0] rexp;
   } sb_t;
   sb_t sb_q[$];

   logic [7:0] ref_mem [logic [19:0]];
   int          m_ph = 0;
   logic        m_valid = 1'b0;
   logic        m_who = 1'b0, m_we = 1'b0, m_ptr = 1'b0;
   logic [19:0] m_addr = '0;
   logic [7:0]  m_wd = '0, m_rdata = '0;

   function automatic logic [7:0] ref_rd(input logic [19:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // {ALE, CS, RD, WR, gnt0, gnt1, done0, done1, busy} for each bus-cycle phase.
   function automatic logic [8:0] exp_ctl(input int ph, input logic who, input logic we);
      case (ph)
         1:       return {1'b1, 1'b0, 1'b1, 1'b1, ~who, who, 2'b00, 1'b1};
         2, 3:    return {1'b0, 1'b0, we, ~we, ~who, who, 2'b00, 1'b1};
         4:       return {1'b0, 1'b1, 1'b1, 1'b1, ~who, who, ~who, who, 1'b1};
         default: return 9'b0_1_1_1_0_0_0_0_0;
      endcase
   endfunction

   always @(negedge clk) begin
      sb_t it;
      if (m_valid) begin
         chk("ctl", {23'd0, ALE, CS, RD, WR, gnt0, gnt1, done0, done1, busy},
             {23'd0, exp_ctl(m_ph, m_who, m_we)});
         chk("address", {12'd0, Address}, {12'd0, m_addr});
         chk("rdata_hold", {24'd0, rdata}, {24'd0, m_rdata});
         if (m_we && m_ph >= 2) chk("wr_data_bus", {24'd0, data_bus}, {24'd0, m_wd});
      end
      if (rst) begin
         if (m_ph >= 1 && m_ph <= 3) void'(sb_q.pop_back());
         m_ph = 0; m_addr = '0; m_rdata = '0; m_ptr = 1'b0; m_we = 1'b0; m_who = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         case (m_ph)
            0: if (req0 || req1) begin
                  m_who  = (req0 && req1) ? m_ptr : req1;
                  m_ptr  = ~m_who;
                  m_we   = m_who ? we1 : we0;
                  m_addr = m_who ? addr1 : addr0;
                  m_wd   = m_who ? wdata1 : wdata0;
                  it.who = m_who; it.we = m_we; it.rexp = ref_rd(m_addr);
                  sb_q.push_back(it);
                  m_ph = 1;
               end
            1, 2: m_ph = m_ph + 1;
            3: begin
                  if (m_we) ref_mem[m_addr] = m_wd;
                  else m_rdata = ref_rd(m_addr);
                  m_ph = 4;
               end
            default: m_ph = 0;
         endcase
      end
   end

   int done_cnt0 = 0, done_cnt1 = 0;

   always @(negedge clk) begin
      sb_t it;
      if (m_valid && (done0 || done1)) begin
         if (done0) done_cnt0++;
         if (done1) done_cnt1++;
         if (sb_q.size() == 0) chk("done_unexpected", {30'd0, done1, done0}, 32'd0);
         else begin
            it = sb_q.pop_front();
            chk("done_who", {30'd0, done1, done0}, it.who ? 32'd2 : 32'd1);
            if (!it.we) chk("read_data", {24'd0, rdata}, {24'd0, it.rexp});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input int n, input logic we, input logic [19:0] a, input logic [7:0] d);
      if (n == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic wait_done(input int n);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (n == 0) ? done0 : done1;
      end
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout requester=%0d actual=no_done required=done", n);
      end
      @(posedge clk); #1;
      if (n == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   function automatic logic [19:0] pick_addr();
      case ($urandom % 6)
         0: return 20'h00001;
         1: return 20'h00002;
         2: return 20'h00010;
         3: return 20'h00020;
         4: return 20'hFFFFF;
         default: return 20'($urandom);
      endcase
   endfunction

   int last0 = 0, last1 = 0;

   task automatic rnd_step(input int n);
      logic r, fresh, seen;
      r    = (n == 0) ? req0 : req1;
      seen = (n == 0) ? (done_cnt0 != last0) : (done_cnt1 != last1);
      if (n == 0) last0 = done_cnt0; else last1 = done_cnt1;
      fresh = 1'b0;
      if (seen) begin r = 1'($urandom % 2); fresh = r; end
      else if (!r) begin r = ($urandom % 3 == 0); fresh = r; end
      else begin
         fresh = ($urandom % 4 == 0);
         if ($urandom % 16 == 0) r = 1'b0;
      end
      if (n == 0) begin
         req0 = r;
         if (fresh) begin we0 = 1'($urandom); addr0 = pick_addr(); wdata0 = 8'($urandom); end
      end else begin
         req1 = r;
         if (fresh) begin we1 = 1'($urandom); addr1 = pick_addr(); wdata1 = 8'($urandom); end
      end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

      // Contention from reset: reads of 0x00001 / 0x00002 alternate 0,1,0,1.
      issue(0, 1'b0, 20'h00001, 8'h00);
      issue(1, 1'b0, 20'h00002, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 req0 = 1'b0; req1 = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Single read of 0x00010.
      issue(0, 1'b0, 20'h00010, 8'h00);
      wait_done(0);
      repeat (2) @(posedge clk);
      #1;

      // Write 0x3C to the top address, then read it back.
      issue(1, 1'b1, 20'hFFFFF, 8'h3C);
      wait_done(1);
      issue(1, 1'b0, 20'hFFFFF, 8'h00);
      wait_done(1);
      repeat (2) @(posedge clk);
      #1;

      // One-cycle request pulse, with the inputs scrambled during T2.
      issue(0, 1'b0, 20'h00001, 8'h00);
      @(posedge clk); #1 req0 = 1'b0;
      @(posedge clk); #1 addr0 = 20'h55555; we0 = 1'b1; wdata0 = 8'hEE;
      repeat (8) @(posedge clk);
      #1;

      // Reset during T3 of a write to 0x00020: no done, memory keeps 0x11.
      issue(0, 1'b1, 20'h00020, 8'h77);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         if (m_ph == 3) break;
      end
      #1 rst = 1'b1; req0 = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Simultaneous requests right after reset: requester 0 must win first.
      issue(0, 1'b0, 20'h00020, 8'h00);
      issue(1, 1'b0, 20'h00002, 8'h00);
      wait_done(0);
      wait_done(1);
      repeat (2) @(posedge clk);
      #1;

      // Random traffic.
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         rnd_step(0);
         rnd_step(1);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
